// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and default widths for the APB master bridge
package apb_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STB_WIDTH      = DEF_DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog: ACCESS-phase wait counter, expires on the LIMIT-th stalled cycle
// Ports: clk/rst clock and async active-high reset; i_clr zeroes the count;
// i_en marks a stalled ACCESS cycle; o_expired is high in the stalled cycle that reaches LIMIT.
// Used by apb_master only when APB_TIMEOUT_EN is defined.
module apb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CW'(1);
  // the increment in this cycle would reach LIMIT, so abort now
  assign o_expired = i_en && r_cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/apb_master.sv
// apb_master: CPU load/store to APB bridge, one transfer at a time (IDLE -> SETUP -> ACCESS)
// Ports: pclk/preset clock and async active-high reset;
// cpu_req/addr/wdata/we/stb request in, cpu_ready idle flag, cpu_ack/rdata/err completion out;
// paddr/pdata/psel/penable/pwrite/pstb APB outputs, prdata/pready/perr APB inputs.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES stalled cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cpu_req,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic                    cpu_we,
  input  logic [DATA_WIDTH/8-1:0] cpu_stb,
  output logic                    cpu_ready,
  output logic                    cpu_ack,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  input  logic                    pready,
  input  logic                    perr
);
  apb_state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_pstb;
  logic r_pwrite, r_ack, r_err;
  logic w_done, w_abort;
  assign w_done = r_state == ACCESS && pready;
`ifdef APB_TIMEOUT_EN
  logic w_expired;
  apb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk      (pclk),
    .rst      (preset),
    .i_clr    (r_state == SETUP),
    .i_en     (r_state == ACCESS && !pready),
    .o_expired(w_expired)
  );
  assign w_abort = w_expired;
`else
  assign w_abort = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (cpu_req ? SETUP : IDLE) :
             r_state == SETUP ? ACCESS :
             (w_done || w_abort) ? IDLE : ACCESS;
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      r_state  <= IDLE;
      r_paddr  <= '0;
      r_pdata  <= '0;
      r_pwrite <= 1'b0;
      r_pstb   <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_done || w_abort;
      if (r_state == IDLE && cpu_req) begin
        r_paddr  <= cpu_addr;
        r_pdata  <= cpu_wdata;
        r_pwrite <= cpu_we;
        r_pstb   <= cpu_we ? cpu_stb : '0;
      end
      if (w_done) begin
        r_rdata <= r_pwrite ? '0 : prdata;
        r_err   <= perr;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  // bus controls decode straight from state so reset drops them asynchronously
  assign psel      = r_state != IDLE;
  assign penable   = r_state == ACCESS;
  assign cpu_ready = r_state == IDLE;
  assign cpu_ack   = r_ack;
  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;
  assign paddr     = r_paddr;
  assign pdata     = r_pdata;
  assign pwrite    = r_pwrite;
  assign pstb      = r_pstb;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed stimulus with a transaction-age model checked every cycle
module tb_apb_master;
  localparam int TO = 4;
  logic pclk = 1'b0, preset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, pready = 1'b1, perr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, prdata = '0;
  logic [3:0] cpu_stb = '0;
  logic cpu_ready, cpu_ack, cpu_err, psel, penable, pwrite;
  logic [31:0] cpu_rdata, paddr, pdata;
  logic [3:0] pstb;
  int n_checks = 0, n_errors = 0;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_stb(cpu_stb), .cpu_ready(cpu_ready),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .paddr(paddr),
    .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pstb(pstb), .pready(pready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Model: a transfer is tracked by its age in cycles since acceptance
  // (age 1 = setup cycle, age >= 2 = access cycles).
  logic m_busy = 1'b0, m_ack = 1'b0, m_we = 1'b0, m_err = 1'b0;
  int m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0] m_stb = '0;

  always @(posedge pclk or posedge preset)
    if (preset) begin
      m_busy = 0; m_ack = 0; m_we = 0; m_err = 0; m_age = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_stb = 0;
    end else begin
      m_ack = 0;
      if (!m_busy) begin
        if (cpu_req) begin
          m_busy = 1; m_age = 1; m_addr = cpu_addr; m_wdata = cpu_wdata;
          m_we = cpu_we; m_stb = cpu_we ? cpu_stb : 4'h0;
        end
      end else if (m_age >= 2 && pready) begin
        m_busy = 0; m_ack = 1; m_rdata = m_we ? 32'h0 : prdata; m_err = perr;
      end
`ifdef APB_TIMEOUT_EN
      else if (m_age - 1 == TO) begin
        m_busy = 0; m_ack = 1; m_rdata = 0; m_err = 1;
      end
`endif
      else m_age++;
    end

  always @(negedge pclk) begin
    check("ready", cpu_ready, !m_busy);
    check("psel", psel, m_busy);
    check("penable", penable, m_busy && m_age >= 2);
    check("ack", cpu_ack, m_ack);
    check("rdata", cpu_rdata, m_rdata);
    check("err", cpu_err, m_err);
    check("paddr", paddr, m_addr);
    check("pdata", pdata, m_wdata);
    check("pwrite", pwrite, m_we);
    check("pstb", pstb, m_stb);
  end

  int acks;

  initial begin
    #1 preset = 1'b1;
    @(negedge pclk);
    check("rst_ready", cpu_ready, 1);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_ack", cpu_ack, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rdata", cpu_rdata, 0);
    tick(); preset = 1'b0;
    tick();
    cpu_req = 1; cpu_addr = 32'h100; cpu_we = 0; cpu_stb = 4'hF; prdata = 32'hDEADBEEF;
    @(negedge pclk); check("rd_n_psel", psel, 0);
    tick(); cpu_req = 0;
    @(negedge pclk); check("rd_n1_psel", psel, 1); check("rd_n1_penable", penable, 0);
    tick();
    @(negedge pclk); check("rd_n2_penable", penable, 1); check("rd_n2_pstb", pstb, 0);
    tick();
    @(negedge pclk); check("rd_n3_ack", cpu_ack, 1);
    check("rd_n3_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_n3_err", cpu_err, 0); check("rd_n3_psel", psel, 0);
    tick();
    cpu_req = 1; cpu_addr = 32'h204; cpu_wdata = 32'h12345678; cpu_we = 1; cpu_stb = 4'b0011;
    pready = 0; prdata = 32'hCAFEF00D;
    tick(); cpu_req = 0; cpu_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge pclk);
      check("wr_wait_paddr", paddr, 32'h204); check("wr_wait_pdata", pdata, 32'h12345678);
      check("wr_wait_pstb", pstb, 4'b0011); check("wr_wait_ack", cpu_ack, 0);
    end
    tick(); pready = 1;
    tick();
    @(negedge pclk); check("wr_n6_ack", cpu_ack, 1); check("wr_n6_rdata", cpu_rdata, 0);
    tick(); cpu_req = 1; cpu_addr = 32'h300; cpu_we = 0; perr = 1; prdata = 32'h55;
    tick(); cpu_req = 0;
    tick(); tick();
    @(negedge pclk); check("err_ack", cpu_ack, 1); check("err_flag", cpu_err, 1);
    check("err_rdata", cpu_rdata, 32'h55);
    tick(); perr = 0; cpu_req = 1; cpu_addr = 32'h304; prdata = 32'h66;
    tick(); cpu_req = 0;
    tick(); tick();
    @(negedge pclk); check("clean_ack", cpu_ack, 1); check("clean_err", cpu_err, 0);
    check("clean_rdata", cpu_rdata, 32'h66);
    tick(); cpu_req = 1; cpu_addr = 32'h400; prdata = 32'h11;
    tick(); cpu_addr = 32'h404; prdata = 32'h22;
    tick();
    @(negedge pclk); check("b2b_first_paddr", paddr, 32'h400);
    tick(); prdata = 32'h33;
    @(negedge pclk); check("b2b_ack1", cpu_ack, 1); check("b2b_ack_psel", psel, 0);
    check("b2b_ack_ready", cpu_ready, 1); check("b2b_rdata1", cpu_rdata, 32'h22);
    tick(); cpu_req = 0;
    @(negedge pclk); check("b2b_setup2_psel", psel, 1); check("b2b_setup2_paddr", paddr, 32'h404);
    tick(); tick();
    @(negedge pclk); check("b2b_ack2", cpu_ack, 1); check("b2b_rdata2", cpu_rdata, 32'h33);
    tick(); cpu_req = 1; cpu_addr = 32'h500; cpu_we = 1; cpu_wdata = 32'hA5; cpu_stb = 4'hF; pready = 0;
    tick(); cpu_req = 0;
    tick();
    @(negedge pclk); check("rst_mid_penable", penable, 1);
    #2 preset = 1'b1;
    #1 check("rst_mid_psel", psel, 0); check("rst_mid_pen", penable, 0);
    check("rst_mid_ready", cpu_ready, 1);
    tick(); preset = 1'b0;
    repeat (3) begin
      @(negedge pclk); check("rst_after_ack", cpu_ack, 0); check("rst_after_ready", cpu_ready, 1);
    end
    tick(); cpu_req = 1; cpu_addr = 32'h600; cpu_we = 0; pready = 0; prdata = 32'h99;
    tick(); cpu_req = 0;
`ifdef APB_TIMEOUT_EN
    repeat (TO) begin
      tick();
      @(negedge pclk); check("to_wait_psel", psel, 1); check("to_wait_ack", cpu_ack, 0);
    end
    tick();
    @(negedge pclk); check("to_ack", cpu_ack, 1); check("to_err", cpu_err, 1);
    check("to_rdata", cpu_rdata, 0); check("to_psel", psel, 0);
    pready = 1;
`else
    acks = 0;
    repeat (300) begin
      @(negedge pclk);
      if (cpu_ack) acks++;
    end
    check("no_timeout_acks", acks, 0); check("no_timeout_penable", penable, 1);
    tick(); pready = 1; prdata = 32'h77;
    tick();
    @(negedge pclk); check("late_ack", cpu_ack, 1); check("late_rdata", cpu_rdata, 32'h77);
`endif
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Bridge between the core's load/store port and the APB bus; sits directly upstream of the APB slave/SRAM stage and drives its psel/penable/paddr/pdata/pwrite/pstb.
- Accepts one CPU request at a time and sequences it through the APB SETUP and ACCESS phases.
- Waits for pready, then returns read data and error status to the core with a one-cycle ack pulse.

Parameters:
- ADDR_WIDTH, 32, address width of the CPU and APB buses.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8 (4 at the default).
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only when APB_TIMEOUT_EN is defined.

Ports:
- pclk  in  1  bus clock; all state is on the rising edge.
- preset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid; sampled only while cpu_ready=1.
- cpu_addr  in  ADDR_WIDTH  request address.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_we  in  1  1=write, 0=read.
- cpu_stb  in  DATA_WIDTH/8  byte strobes for writes.
- cpu_ready  out  1  bridge idle, can accept a request.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data; valid while cpu_ack=1.
- cpu_err  out  1  error flag; valid while cpu_ack=1.
- paddr  out  ADDR_WIDTH  APB address.
- pdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pstb  out  DATA_WIDTH/8  APB write strobes.
- pready  in  1  slave ready.
- perr  in  1  slave error.

Behaviour:
- Reset (async, preset=1): state=IDLE. psel, penable, pwrite, cpu_ack and cpu_err are 0. paddr, pdata, pstb and cpu_rdata are 0. cpu_ready=1.
- States are IDLE, SETUP, ACCESS. cpu_ready is combinational: it equals (state==IDLE).
- IDLE:
  - If cpu_req=1, register cpu_addr to paddr, cpu_wdata to pdata, cpu_we to pwrite, and pstb. Go to SETUP.
  - pstb = cpu_stb when cpu_we=1; pstb = 0 for reads.
  - Otherwise stay in IDLE.
- SETUP: psel=1, penable=0 for exactly one cycle. Go to ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=0: hold; paddr, pdata, pwrite and pstb stay stable.
  - pready=1: capture prdata into cpu_rdata and perr into cpu_err, and pulse cpu_ack=1 for one cycle. Drop psel and penable that same edge. Go to IDLE.
- cpu_rdata on writes: loaded with 0. It holds its value until the next completion.
- Latency: request in cycle N gives SETUP in N+1 and ACCESS in N+2. pready=1 in cycle N+1+k (k≥1 ACCESS cycles) gives cpu_ack in cycle N+2+k.
- Minimum request-to-ack latency is 3 cycles.
- cpu_ready returns to 1 in the ack cycle. A new cpu_req seen in the ack cycle is accepted, so back-to-back transfers have a period of 3 cycles.
- psel is never asserted in IDLE. penable is never 1 without psel.
- Exactly one SETUP cycle precedes every ACCESS phase.
- cpu_req while busy is ignored; the core must hold the request until cpu_ready.
- pready/perr outside ACCESS are ignored.
- Reset mid-transfer: psel and penable drop immediately (asynchronously). No cpu_ack is produced.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: psel and penable drop, cpu_ack=1, cpu_err=1, cpu_rdata=0, state goes to IDLE.
  - pready=1 in the same cycle as the limit wins, and the transfer completes normally.
- Undefined: no counter; the bridge waits for pready indefinitely.

Decomposition:
- Package apb_pkg:
  - state enum apb_state_t {IDLE, SETUP, ACCESS}
  - default ADDR_WIDTH and DATA_WIDTH constants
  - STB_WIDTH = DATA_WIDTH/8
- One sub-module, apb_watchdog: the timeout counter with clear/enable inputs and an expired output. It is instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Read, zero wait: cpu_req, addr=0x100, we=0; slave has pready=1 with prdata=0xDEADBEEF → psel rises at N+1, penable at N+2, cpu_ack at N+3 with cpu_rdata=0xDEADBEEF, cpu_err=0, and pstb=0 throughout.
- Write, 3 waits: addr=0x204, wdata=0x12345678, stb=4'b0011; pready low for 3 ACCESS cycles → paddr/pdata/pstb stable through all wait cycles, cpu_ack at N+6, cpu_rdata=0.
- Error: read with perr=1 and pready=1 → cpu_ack with cpu_err=1, then a clean read returns cpu_err=0.
- Back-to-back: cpu_req held high for two transfers → second SETUP immediately follows the first ack cycle, and there is no IDLE gap in psel beyond one cycle.
- Reset in ACCESS: assert preset mid-wait → psel and penable fall in the same cycle, no cpu_ack, and cpu_ready=1 after release.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 → abort after 4 ACCESS cycles with cpu_ack=1, cpu_err=1, cpu_rdata=0, psel=0.
